// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit arbiter slice.
package uart_pkg;

  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned CNT_W           = 8;
  localparam int unsigned TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_SEND    = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first requester strictly after `last`, wrapping modulo NUM_REQ.
module uart_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] requests,
  input  logic [IW-1:0]      last,
  output logic [NUM_REQ-1:0] winner,
  output logic [IW-1:0]      index
);

  int unsigned k;
  logic        found;

  always_comb begin
    winner = '0;
    index  = '0;
    found  = 1'b0;
    k      = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      k = (32'(last) + i) % NUM_REQ;
      if (!found && requests[IW'(k)]) begin
        found             = 1'b1;
        winner[IW'(k)]    = 1'b1;
        index             = IW'(k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UartTx between NUM_REQ byte requesters with round-robin fairness
// and a write/busy handshake timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                      clock_i,
  input  logic                      reset_ni,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [BYTE_W*NUM_REQ-1:0] data_i,
  output logic [NUM_REQ-1:0]        ack_o,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      tx_write_o,
  output logic [BYTE_W-1:0]         tx_data_o,
  input  logic                      tx_busy_i,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  arb_state_e         state;
  logic [CNT_W-1:0]   cnt;
  logic [IW-1:0]      last;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IW-1:0]      pick_idx;
  logic [BYTE_W-1:0]  bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign bytes[g] = data_i[BYTE_W*g +: BYTE_W];
  end

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .requests (req_i),
    .last     (last),
    .winner   (pick_onehot),
    .index    (pick_idx)
  );

  // The pointer moves at grant time, so a timed-out requester is skipped next round.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      last       <= IW'(NUM_REQ - 1);
      grant_o    <= '0;
      ack_o      <= '0;
      tx_write_o <= 1'b0;
      tx_data_o  <= 8'h00;
      busy_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      ack_o <= '0;
      err_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (|req_i && !tx_busy_i) begin
            state      <= ST_REQUEST;
            grant_o    <= pick_onehot;
            ack_o      <= pick_onehot;
            tx_data_o  <= bytes[pick_idx];
            last       <= pick_idx;
            tx_write_o <= 1'b1;
            busy_o     <= 1'b1;
            cnt        <= '0;
          end
        end
        ST_REQUEST: begin
          if (tx_busy_i) begin
            state      <= ST_SEND;
            tx_write_o <= 1'b0;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state      <= ST_IDLE;
            err_o      <= 1'b1;
            grant_o    <= '0;
            tx_write_o <= 1'b0;
            busy_o     <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_SEND: begin
          if (!tx_busy_i) begin
            state   <= ST_IDLE;
            grant_o <= '0;
            busy_o  <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          grant_o    <= '0;
          tx_write_o <= 1'b0;
          busy_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT=16).
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic        tx_write;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        busy;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_arbiter #(
    .NUM_REQ (4),
    .TIMEOUT (16)
  ) dut (
    .clock_i    (clk),
    .reset_ni   (rst_n),
    .req_i      (req),
    .data_i     (data),
    .ack_o      (ack),
    .grant_o    (grant),
    .tx_write_o (tx_write),
    .tx_data_o  (tx_data),
    .tx_busy_i  (tx_busy),
    .busy_o     (busy),
    .err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'h0);
    check({tag, "_ack"}, 32'(ack), 32'h0);
    check({tag, "_write"}, 32'(tx_write), 32'h0);
    check({tag, "_data"}, 32'(tx_data), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
  endtask

  // Called right after the grant edge; runs the busy handshake back to IDLE.
  task automatic serve(input int idx, input logic [7:0] b);
    logic [3:0] oh;
    oh = 4'(1 << idx);
    check("srv_grant", 32'(grant), 32'(oh));
    check("srv_ack", 32'(ack), 32'(oh));
    check("srv_write", 32'(tx_write), 32'h1);
    check("srv_data", 32'(tx_data), 32'(b));
    tx_busy = 1'b1;
    tick();
    check("srv_ack_once", 32'(ack), 32'h0);
    check("srv_write_low", 32'(tx_write), 32'h0);
    repeat (3) tick();
    check("srv_hold_grant", 32'(grant), 32'(oh));
    tx_busy = 1'b0;
    tick();
    check("srv_idle_grant", 32'(grant), 32'h0);
    check("srv_idle_busy", 32'(busy), 32'h0);
  endtask

  task automatic do_reset();
    req     = '0;
    tx_busy = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int order [5];
    order = '{0, 1, 2, 3, 0};
    req     = '0;
    data    = 32'h0000_0055;
    tx_busy = 1'b0;
    rst_n   = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request; data_i changes after ack must not disturb tx_data.
    req = 4'b0001;
    tick();
    check("single_ack", 32'(ack), 32'h1);
    check("single_write", 32'(tx_write), 32'h1);
    check("single_data", 32'(tx_data), 32'h55);
    check("single_busy", 32'(busy), 32'h1);
    req  = '0;
    data = 32'h0000_00FF;
    tick();
    check("single_ack_pulse", 32'(ack), 32'h0);
    check("single_write_hold", 32'(tx_write), 32'h1);
    tx_busy = 1'b1;
    tick();
    check("single_send_write", 32'(tx_write), 32'h0);
    repeat (10) tick();
    check("single_data_stable", 32'(tx_data), 32'h55);
    check("single_send_busy", 32'(busy), 32'h1);
    tx_busy = 1'b0;
    tick();
    check("single_idle_grant", 32'(grant), 32'h0);
    check("single_idle_busy", 32'(busy), 32'h0);

    // Contention from reset: 0,1,2,3,0.
    do_reset();
    data = 32'hA3A2_A1A0;
    req  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      serve(order[i], 8'(8'hA0 + order[i]));
    end
    req = '0;

    // Pointer wrap: 2 wins, then {0,1} gives 0 before 1.
    req = 4'b0100;
    tick();
    serve(2, 8'hA2);
    req = 4'b0011;
    tick();
    serve(0, 8'hA0);
    tick();
    serve(1, 8'hA1);
    req = '0;

    // Timeout on requester 2 with tx_busy held low.
    req = 4'b0100;
    tick();
    check("to_write", 32'(tx_write), 32'h1);
    check("to_grant", 32'(grant), 32'h4);
    req = '0;
    n = 0;
    while (!err && n < 40) begin
      tick();
      n++;
    end
    check("to_latency", 32'(n), 32'd16);
    check("to_grant_clr", 32'(grant), 32'h0);
    check("to_write_clr", 32'(tx_write), 32'h0);
    check("to_busy_clr", 32'(busy), 32'h0);
    tick();
    check("to_err_pulse", 32'(err), 32'h0);
    req = 4'b1100;
    tick();
    serve(3, 8'hA3);
    req = '0;

    // Asynchronous reset in the middle of requester 1's SEND.
    req = 4'b0010;
    tick();
    check("rs_grant", 32'(grant), 32'h2);
    tx_busy = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rs_async");
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("rs_holdoff1", 32'(grant), 32'h0);
    tick();
    check("rs_holdoff2", 32'(grant), 32'h0);
    tx_busy = 1'b0;
    tick();
    serve(1, 8'hA1);
    req = '0;

    // Busy hold-off in IDLE.
    tx_busy = 1'b1;
    req     = 4'b0100;
    repeat (3) begin
      tick();
      check("bh_nogrant", 32'(grant), 32'h0);
    end
    tx_busy = 1'b0;
    tick();
    serve(2, 8'hA2);
    req = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one UartTx, legal range 2..8.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles to wait for tx_busy_i after asserting tx_write_o, legal range 2..255.
REQ-003 clock_i  in  1  single clock; all logic on its rising edge.
REQ-004 reset_ni  in  1  asynchronous reset, active-low.
REQ-005 req_i  in  NUM_REQ  level request per requester; bit k set means requester k has a byte pending.
REQ-006 data_i  in  8*NUM_REQ  packed bytes; requester k drives bits [8k+7:8k].
REQ-007 ack_o  out  NUM_REQ  one-cycle pulse; bit k set means requester k's byte was latched.
REQ-008 grant_o  out  NUM_REQ  one-hot current owner, all-zero when idle.
REQ-009 tx_write_o  out  1  to UartTx write_i.
REQ-010 tx_data_o  out  8  to UartTx data_i.
REQ-011 tx_busy_i  in  1  from UartTx busy_o.
REQ-012 busy_o  out  1  high in any state other than IDLE.
REQ-013 err_o  out  1  one-cycle pulse on handshake timeout.

Function
REQ-014 The FSM SHALL have three states: IDLE, REQUEST and SEND.
REQ-015 IDLE: if any req_i bit is set and tx_busy_i=0, the FSM SHALL go to REQUEST on the next edge, setting grant_o to the round-robin winner, loading tx_data_o with the winner's byte, and pulsing ack_o of the winner during that same cycle.
REQ-016 IDLE with tx_busy_i=1 SHALL NOT grant; requests are held off until tx_busy_i=0.
REQ-017 Round-robin: search starts at the requester after the last winner and wraps modulo NUM_REQ; after reset, requester 0 has highest priority.
REQ-018 REQUEST: tx_write_o=1; on tx_busy_i=1, the FSM SHALL go to SEND with tx_write_o=0 on the following cycle.
REQ-019 REQUEST: a cycle counter starts at 0 on entry; if it reaches TIMEOUT-1 with tx_busy_i=0, the FSM SHALL pulse err_o, clear grant_o and return to IDLE.
REQ-020 After a timeout, the last-winner pointer SHALL still advance past the timed-out requester; its byte is considered consumed and is not retried.
REQ-021 SEND: on tx_busy_i=0, the FSM SHALL return to IDLE and clear grant_o on the same edge.
REQ-022 Latency SHALL be 1 cycle from a req_i sample in IDLE to tx_write_o high; a new grant SHALL occur at the earliest 1 cycle after returning to IDLE.
REQ-023 tx_data_o SHALL stay stable from grant until the return to IDLE; changes on data_i after ack_o SHALL be ignored.
REQ-024 req_i is level-sensitive: a requester still asserting after ack_o is re-arbitrated as a new byte; a req_i drop at any time other than the sampling IDLE cycle has no effect.
REQ-025 Simultaneous requests SHALL be resolved by round-robin only; no requester can be granted twice while another is continuously requesting.

Reset
REQ-026 When reset_ni=0: state=IDLE, grant_o=0, ack_o=0, tx_write_o=0, tx_data_o=8'h00, busy_o=0, err_o=0, counter=0 and last-winner pointer=NUM_REQ-1.
REQ-027 Reset mid-transfer SHALL abort immediately; the in-flight byte is not retried, and after release the first grant follows REQ-016.

Structure
REQ-028 State encodings (IDLE=2'd0, REQUEST=2'd1, SEND=2'd2) and the default TIMEOUT SHALL be constants in the shared uart_pkg.
REQ-029 The round-robin picker SHALL be one sub-module, uart_rr_pick, with inputs requests and last pointer, and outputs one-hot winner plus index.

Verification
REQ-030 Single request: req_i=4'b0001, data 8'h55 -> ack_o[0] pulse, tx_write_o high next cycle; UartTx (clock_divider_i=1) serialises 8'h55; return to IDLE when tx_busy_i falls.
REQ-031 Contention: req_i=4'b1111 held, bytes 8'hA0..8'hA3 -> grant order 0,1,2,3,0; exactly one ack_o per grant.
REQ-032 Pointer wrap: after requester 2 wins, req_i=4'b0011 -> requester 0 wins before requester 1.
REQ-033 Timeout: tx_busy_i tied 0, TIMEOUT=16 -> err_o pulse exactly 16 cycles after tx_write_o rises; grant_o=0; next requester is served.
REQ-034 Reset mid-SEND: reset_ni low during requester 1's byte -> all outputs at their reset values asynchronously; after release with req_i=4'b0010, requester 1 is granted once tx_busy_i=0.
REQ-035 Busy hold-off: tx_busy_i=1 in IDLE with req_i=4'b0100 -> no grant until tx_busy_i=0, then grant in the following cycle.
